// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: parity encodings, frame bit positions and
// deframer FSM state codes.
package uart_rx_pkg;

  localparam logic [1:0] PAR_NONE0 = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_NONE3 = 2'b11;

  localparam int unsigned START_BIT = 10;
  localparam int unsigned D0_BIT    = 9;
  localparam int unsigned PAR_BIT   = 1;
  localparam int unsigned STOP_BIT  = 0;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CHECK = 1'b1;

endpackage

// File: rtl/rx_parity_check.sv
// Combinational parity checker: flags a mismatch between the received parity
// bit and the parity implied by the data byte and the selected parity mode.
module rx_parity_check
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] data_byte,
  input  logic              parity_bit,
  input  logic [1:0]        parity_type,
  output logic              parity_error_c
);

  logic data_xor;

  assign data_xor = ^data_byte;

  // Both no-parity encodings ignore the received parity bit.
  always_comb begin
    parity_error_c = 1'b0;
    case (parity_type)
      PAR_ODD:  parity_error_c = (parity_bit != ~data_xor);
      PAR_EVEN: parity_error_c = (parity_bit != data_xor);
      default:  parity_error_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/rx_deframe.sv
// UART receive deframer: checks start/stop/parity of a captured frame, presents
// the data byte with a valid/ack handshake, sticky overrun and saturating error count.
module rx_deframe
  import uart_rx_pkg::*;
#(
  parameter int unsigned FRAME_W  = 11,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                baud_clk,
  input  logic                reset_n,
  input  logic                recieved_flag,
  input  logic [FRAME_W-1:0]  data_parll,
  input  logic [1:0]          parity_type,
  input  logic                rd_ack,
  output logic [DATA_W-1:0]   data_out,
  output logic                data_valid,
  output logic                parity_error,
  output logic                start_error,
  output logic                stop_error,
  output logic                overrun,
  output logic [ERRCNT_W-1:0] err_count
);

  logic [0:0]          state_q;
  logic [0:0]          state_n;
  logic                flag_d;
  logic                rise;
  logic [FRAME_W-1:0]  frame_q;
  logic [FRAME_W-1:0]  frame_n;
  logic [DATA_W-1:0]   byte_c;
  logic                parity_error_c;
  logic                any_error_c;

  logic [DATA_W-1:0]   data_n;
  logic                valid_n;
  logic                perr_n;
  logic                serr_n;
  logic                sterr_n;
  logic                ovr_n;
  logic [ERRCNT_W-1:0] cnt_n;

  assign rise = recieved_flag & ~flag_d;

  // D0 is transmitted first, so it sits in the highest data position of the frame.
  always_comb begin
    byte_c = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      byte_c[i] = frame_q[D0_BIT-i];
    end
  end

  rx_parity_check #(
    .DATA_W (DATA_W)
  ) u_parity (
    .data_byte      (byte_c),
    .parity_bit     (frame_q[PAR_BIT]),
    .parity_type    (parity_type),
    .parity_error_c (parity_error_c)
  );

  assign any_error_c = parity_error_c | frame_q[START_BIT] | ~frame_q[STOP_BIT];

  // Next-state and next-output logic; the CHECK set of data_valid overrides an ack.
  always_comb begin
    state_n = state_q;
    frame_n = frame_q;
    data_n  = data_out;
    valid_n = data_valid;
    perr_n  = parity_error;
    serr_n  = start_error;
    sterr_n = stop_error;
    ovr_n   = overrun;
    cnt_n   = err_count;

    if (data_valid && rd_ack) begin
      valid_n = 1'b0;
      ovr_n   = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (rise) begin
          frame_n = data_parll;
          state_n = CHECK;
          if (data_valid && !rd_ack) begin
            ovr_n = 1'b1;
          end
        end
      end
      CHECK: begin
        data_n  = byte_c;
        perr_n  = parity_error_c;
        serr_n  = frame_q[START_BIT];
        sterr_n = ~frame_q[STOP_BIT];
        valid_n = 1'b1;
        if (any_error_c && (err_count != {ERRCNT_W{1'b1}})) begin
          cnt_n = err_count + ERRCNT_W'(1);
        end
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      flag_d       <= 1'b0;
      frame_q      <= '0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      start_error  <= 1'b0;
      stop_error   <= 1'b0;
      overrun      <= 1'b0;
      err_count    <= '0;
    end else begin
      state_q      <= state_n;
      flag_d       <= recieved_flag;
      frame_q      <= frame_n;
      data_out     <= data_n;
      data_valid   <= valid_n;
      parity_error <= perr_n;
      start_error  <= serr_n;
      stop_error   <= sterr_n;
      overrun      <= ovr_n;
      err_count    <= cnt_n;
    end
  end

endmodule

// File: tb/tb_rx_deframe.sv
// Self-checking bench for rx_deframe: directed scenarios plus randomized frames
// compared against a frame-level behavioural model.
module tb_rx_deframe;

  logic        baud_clk;
  logic        reset_n;
  logic        recieved_flag;
  logic [10:0] data_parll;
  logic [1:0]  parity_type;
  logic        rd_ack;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        parity_error;
  logic        start_error;
  logic        stop_error;
  logic        overrun;
  logic [7:0]  err_count;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_data;
  logic       exp_valid, exp_perr, exp_serr, exp_sterr, exp_ovr;
  int         exp_cnt;

  rx_deframe dut (
    .baud_clk      (baud_clk),
    .reset_n       (reset_n),
    .recieved_flag (recieved_flag),
    .data_parll    (data_parll),
    .parity_type   (parity_type),
    .rd_ack        (rd_ack),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .parity_error  (parity_error),
    .start_error   (start_error),
    .stop_error    (stop_error),
    .overrun       (overrun),
    .err_count     (err_count)
  );

  initial begin
    baud_clk = 1'b0;
    forever #5 baud_clk = ~baud_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    exp_data = '0; exp_valid = 0; exp_perr = 0; exp_serr = 0;
    exp_sterr = 0; exp_ovr = 0; exp_cnt = 0;
  endfunction

  // Frame-level evaluation: byte is the data field read D0-first, parity by counting ones.
  function automatic void model_frame(input logic [10:0] f, input logic [1:0] pt);
    logic [7:0] d;
    int ones;
    d = f[9:2];
    exp_data = {<<{d}};
    ones = $countones(d) + int'(f[1]);
    if (pt == 2'b01)      exp_perr = (ones % 2 == 0);
    else if (pt == 2'b10) exp_perr = (ones % 2 == 1);
    else                  exp_perr = 1'b0;
    exp_serr  = f[10];
    exp_sterr = ~f[0];
    if ((exp_perr || exp_serr || exp_sterr) && exp_cnt < 255) exp_cnt++;
    exp_valid = 1'b1;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".data"},  32'(data_out),     32'(exp_data));
    chk({tag, ".valid"}, 32'(data_valid),   32'(exp_valid));
    chk({tag, ".perr"},  32'(parity_error), 32'(exp_perr));
    chk({tag, ".serr"},  32'(start_error),  32'(exp_serr));
    chk({tag, ".sterr"}, 32'(stop_error),   32'(exp_sterr));
    chk({tag, ".ovr"},   32'(overrun),      32'(exp_ovr));
    chk({tag, ".cnt"},   32'(err_count),    32'(exp_cnt));
  endtask

  // Sends one frame; called at a falling edge. hold = cycles the flag stays high after CHECK.
  task automatic send(input string tag, input logic [10:0] f, input logic [1:0] pt,
                      input int hold, input bit ack_rise, input bit ack_chk, input bit ack_mid);
    recieved_flag = 1'b1; data_parll = f; parity_type = pt; rd_ack = ack_rise;
    @(negedge baud_clk);
    if (exp_valid) begin
      if (ack_rise) begin exp_valid = 0; exp_ovr = 0; end
      else exp_ovr = 1'b1;
    end
    chk({tag, ".lat_valid"}, 32'(data_valid), 32'(exp_valid));
    chk({tag, ".lat_ovr"},   32'(overrun),    32'(exp_ovr));
    rd_ack = ack_chk;
    @(negedge baud_clk);
    if (exp_valid && ack_chk) exp_ovr = 1'b0;
    model_frame(f, pt);
    check_all(tag);
    rd_ack = 1'b0;
    if (ack_mid) begin
      rd_ack = 1'b1;
      @(negedge baud_clk);
      rd_ack = 1'b0;
      exp_valid = 0; exp_ovr = 0;
    end
    repeat (hold) @(negedge baud_clk);
    chk({tag, ".once_valid"}, 32'(data_valid), 32'(exp_valid));
    chk({tag, ".once_cnt"},   32'(err_count),  32'(exp_cnt));
    recieved_flag = 1'b0;
    @(negedge baud_clk);
  endtask

  task automatic ack(input string tag);
    rd_ack = 1'b1;
    @(negedge baud_clk);
    rd_ack = 1'b0;
    if (exp_valid) begin exp_valid = 0; exp_ovr = 0; end
    chk({tag, ".ack_valid"}, 32'(data_valid), 32'(exp_valid));
    chk({tag, ".ack_ovr"},   32'(overrun),    32'(exp_ovr));
  endtask

  initial begin
    logic [10:0] f;
    logic [1:0]  pt;
    logic [10:0] f6;

    reset_n = 1'b0; recieved_flag = 1'b0; data_parll = '0; parity_type = '0; rd_ack = 1'b0;
    model_clear();
    repeat (2) @(negedge baud_clk);
    check_all("reset");
    reset_n = 1'b1;
    @(negedge baud_clk);

    // Good frame, even parity, long flag with an ack during the hold.
    send("t1_even", 11'h295, 2'b10, 15, 1'b0, 1'b0, 1'b1);
    chk("t1_byte", 32'(exp_data), 32'h0000_00A5);
    // Same frame with odd parity is a parity error.
    send("t2_odd", 11'h295, 2'b01, 2, 1'b0, 1'b0, 1'b0);
    ack("t2");
    // Start and stop errors with parity disabled: one count only.
    send("t3_ss", 11'h694, 2'b00, 2, 1'b0, 1'b0, 1'b0);
    ack("t3");
    // Two good frames without ack -> overrun, latest byte wins.
    send("t4_a", {1'b0, 8'h3C, 1'b0, 1'b1}, 2'b11, 1, 1'b0, 1'b0, 1'b0);
    send("t4_b", {1'b0, 8'hC1, 1'b1, 1'b1}, 2'b00, 1, 1'b0, 1'b0, 1'b0);
    ack("t4");

    // Randomized frames, modes, hold lengths and ack placement.
    for (int i = 0; i < 120; i++) begin
      f  = 11'($urandom);
      if ($urandom_range(0, 3) != 0) begin f[10] = 1'b0; f[0] = 1'b1; end
      pt = 2'($urandom);
      send("rnd", f, pt, $urandom_range(1, 4), 1'($urandom), 1'($urandom), 1'b0);
      if ($urandom_range(0, 2) == 0) ack("rnd");
    end

    // Drive the counter to saturation and one bad frame beyond it.
    while (exp_cnt < 255) begin
      f = 11'($urandom); f[10] = 1'b1;
      send("sat_fill", f, 2'($urandom), 1, 1'b1, 1'b0, 1'b0);
    end
    send("sat_over", 11'h694, 2'b00, 1, 1'b1, 1'b0, 1'b0);
    chk("sat_cnt", 32'(err_count), 32'd255);
    ack("sat");

    // Reset while the frame is waiting in CHECK, flag low at release.
    f6 = {1'b0, 8'h5A, 1'b0, 1'b1};
    recieved_flag = 1'b1; data_parll = f6; parity_type = 2'b10;
    @(negedge baud_clk);
    #1 reset_n = 1'b0;
    #1 model_clear();
    check_all("t6_rst");
    recieved_flag = 1'b0;
    @(negedge baud_clk);
    reset_n = 1'b1;
    repeat (3) @(negedge baud_clk);
    check_all("t6_nopend");

    // Reset mid-frame with the flag still high at release: frame is reprocessed.
    recieved_flag = 1'b1;
    @(negedge baud_clk);
    #1 reset_n = 1'b0;
    @(negedge baud_clk);
    reset_n = 1'b1;
    @(negedge baud_clk);
    chk("t6_relat", 32'(data_valid), 32'd0);
    @(negedge baud_clk);
    model_frame(f6, 2'b10);
    check_all("t6_reproc");
    recieved_flag = 1'b0;
    repeat (2) @(negedge baud_clk);
    ack("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
